// File: rtl/fetch_32.sv
// Instruction fetch stage: owns the PC, issues single-word reads, buffers words in a small FIFO for decode.
// Optional FETCH_PERF_EN adds fetch/redirect performance counters.
module fetch_32 #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSN = 32'h4C00_0000,
   parameter int          FIFO_DEPTH  = 2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        stall_in,
   input  logic        halt_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_data_in,
   output logic [31:0] insn_out,
   output logic [31:0] insn_pc_out,
   output logic        insn_valid_out,
   output logic        align_fault_out
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count_out,
   output logic [15:0] redirect_count_out
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   pc_mem   [FIFO_DEPTH];
   logic [31:0]   data_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          req, push, pop;

   always_ff @(posedge clk_in) begin
      if (reset_in) state <= BOOT;
      else          state <= state_nxt;
   end

   // Halt only takes effect through the state register, so req drops after the sampling edge.
   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            req = (count < FULL_CNT);
            if (halt_in) state_nxt = HOLD;
         end
         HOLD: if (!halt_in) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   assign insn_valid_out = (count != '0);
   assign push           = req && imem_ack_in && !redirect_in;
   assign pop            = insn_valid_out && !stall_in && !redirect_in;

   assign imem_req_out  = req;
   assign imem_addr_out = fetch_pc;
   assign insn_out      = insn_valid_out ? data_mem[rd_ptr] : BUBBLE_INSN;
   assign insn_pc_out   = insn_valid_out ? pc_mem[rd_ptr]   : fetch_pc;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         fetch_pc        <= RESET_PC;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         align_fault_out <= 1'b0;
      end else begin
         align_fault_out <= redirect_in && (redirect_pc_in[1:0] != 2'b00);
         if (redirect_in) begin
            fetch_pc <= {redirect_pc_in[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               pc_mem[wr_ptr]   <= fetch_pc;
               data_mem[wr_ptr] <= imem_data_in;
               wr_ptr           <= wr_ptr + 1'b1;
               fetch_pc         <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         fetch_count_out    <= '0;
         redirect_count_out <= '0;
      end else begin
         if (push) fetch_count_out <= fetch_count_out + 32'd1;
         if (redirect_in && redirect_count_out != 16'hFFFF)
            redirect_count_out <= redirect_count_out + 16'd1;
      end
   end
`endif

endmodule
